// File: rtl/cga_vram_arbiter.sv
// cga_vram_arbiter
//
// Shares the single CGA/Tandy video RAM port between the display sequencer
// and ISA-bus CPU memory cycles. Video fetches always own the RAM. A CPU
// cycle is latched at its start and serviced in the next free RAM cycle. If
// video keeps the RAM busy for MAX_WAIT cycles, the CPU steals one video slot.
// The stolen slot corrupts that video fetch, which shows on screen as "snow".
//
// Parameters
//   USE_BUS_WAIT  1 = hold bus_rdy low while a CPU cycle is outstanding,
//                 0 = bus_rdy tied high
//   MAX_WAIT      blocked cycles in PENDING before a forced steal (1..255)
//   SNOW_STEAL    1 = forced steal enabled, 0 = wait for a free slot forever
//
// Ports
//   clk           system clock
//   reset_l       asynchronous active-low reset
//   vid_req       sequencer owns the RAM this cycle
//   vid_addr      video fetch address
//   cpu_cs        framebuffer window decoded
//   cpu_memr_l    ISA memory read strobe (asynchronous to clk)
//   cpu_memw_l    ISA memory write strobe (asynchronous to clk)
//   cpu_a         offset within the framebuffer window
//   cpu_d         ISA write data
//   tandy_mode    1 = 32K aperture, 0 = 16K mirrored
//   ram_din       RAM read data, valid one clock after the address
//   ram_a         RAM address
//   ram_we_l      RAM write enable, active low
//   ram_dout      RAM write data
//   cpu_q         latched CPU read data
//   bus_rdy       ISA ready
//   snow          one-clock pulse on a forced steal
//   conflict_cnt  saturating count of CPU cycles that were blocked by video

module cga_vram_arbiter #(
  parameter int USE_BUS_WAIT = 1,
  parameter int MAX_WAIT     = 8,
  parameter int SNOW_STEAL   = 1
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        vid_req,
  input  logic [18:0] vid_addr,
  input  logic        cpu_cs,
  input  logic        cpu_memr_l,
  input  logic        cpu_memw_l,
  input  logic [14:0] cpu_a,
  input  logic [7:0]  cpu_d,
  input  logic        tandy_mode,
  input  logic [7:0]  ram_din,
  output logic [18:0] ram_a,
  output logic        ram_we_l,
  output logic [7:0]  ram_dout,
  output logic [7:0]  cpu_q,
  output logic        bus_rdy,
  output logic        snow,
  output logic [15:0] conflict_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PENDING = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // wait_cnt counts the blocked cycles before the current one. The steal is
  // therefore taken on the MAX_WAIT-th blocked cycle.
  localparam int          STEAL_AT_I = MAX_WAIT - 1;
  localparam logic [7:0]  STEAL_AT   = STEAL_AT_I[7:0];
  localparam logic        STEAL_EN   = (SNOW_STEAL != 0);
  localparam logic        BUS_WAIT   = (USE_BUS_WAIT != 0);

  // Map the ISA window offset onto RAM. In 16K mode, A14 is ignored, so the
  // upper half of the window mirrors the lower half.
  function automatic logic [18:0] map_addr(input logic [14:0] a,
                                           input logic        tandy);
    return {4'd0, tandy & a[14], a[13:0]};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state, next_state;

  logic        memr_p0, memr_p1;
  logic        memw_p0, memw_p1;
  logic        active_p2;
  logic        cpu_active;
  logic        start;

  logic        is_write;
  logic [18:0] addr_q;
  logic [7:0]  data_q;

  logic [7:0]  wait_cnt;
  logic        steal;
  logic        steal_set;
  logic        abort;
  logic        blocked;
  logic        bus_rdy_q;

  // Stage p0/p1: two-flop synchronizers for the asynchronous ISA strobes.
  // Stage p2: previous cycle's activity, used for rising-edge start detection.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      memr_p0   <= 1'b1;
      memr_p1   <= 1'b1;
      memw_p0   <= 1'b1;
      memw_p1   <= 1'b1;
      active_p2 <= 1'b0;
    end else begin
      memr_p0   <= cpu_memr_l;
      memr_p1   <= memr_p0;
      memw_p0   <= cpu_memw_l;
      memw_p1   <= memw_p0;
      active_p2 <= cpu_active;
    end
  end

  assign cpu_active = cpu_cs & (~memr_p1 | ~memw_p1);
  assign start      = cpu_active & ~active_p2;

  // A read whose strobe or chip select goes away while it is still waiting
  // is dropped. A write was posted at start and always completes.
  assign abort   = (state == ST_PENDING) && !is_write && (memr_p1 || !cpu_cs);
  assign blocked = (state == ST_PENDING) && !abort && vid_req;

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    steal_set  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (!vid_req) begin
          next_state = ST_ACCESS;
        end else if (STEAL_EN && (wait_cnt == STEAL_AT)) begin
          next_state = ST_ACCESS;
          steal_set  = 1'b1;
        end
      end
      ST_ACCESS: begin
        next_state = is_write ? ST_DONE : ST_CAPTURE;
      end
      ST_CAPTURE: begin
        next_state = ST_DONE;
      end
      ST_DONE: begin
        // New starts are only accepted from IDLE, so the bus has to release
        // the strobes (or leave the window) before the next cycle.
        if ((memr_p1 && memw_p1) || !cpu_cs) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Output logic: the RAM port belongs to video except during ACCESS.
  // When the cycle is a steal, ACCESS also overrides an active vid_req.
  always_comb begin
    ram_a    = vid_addr;
    ram_we_l = 1'b1;
    snow     = 1'b0;
    if (state == ST_ACCESS) begin
      ram_a    = addr_q;
      ram_we_l = ~is_write;
      snow     = steal;
    end
  end

  assign ram_dout = data_q;

  // Request capture at start. Write wins when both strobes are low.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      is_write <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else if ((state == ST_IDLE) && start) begin
      is_write <= ~memw_p1;
      addr_q   <= map_addr(cpu_a, tandy_mode);
      data_q   <= cpu_d;
    end
  end

  // Contention bookkeeping. wait_cnt restarts for every request. steal is
  // only set on the transition into ACCESS, so it is valid exactly during
  // that ACCESS cycle.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      wait_cnt     <= '0;
      steal        <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (state == ST_IDLE) begin
        wait_cnt <= '0;
      end else if (blocked) begin
        wait_cnt <= sat_inc8(wait_cnt);
      end
      if (blocked && (wait_cnt == 8'd0)) begin
        conflict_cnt <= sat_inc16(conflict_cnt);
      end
      steal <= steal_set;
    end
  end

  // Ready and read data. bus_rdy drops on the start edge and rises on the
  // edge that enters DONE or aborts. For reads, that is the same edge that
  // loads cpu_q.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus_rdy_q <= 1'b1;
      cpu_q     <= '0;
    end else begin
      bus_rdy_q <= !((next_state == ST_PENDING) ||
                     (next_state == ST_ACCESS)  ||
                     (next_state == ST_CAPTURE));
      if (state == ST_CAPTURE) begin
        cpu_q <= ram_din;
      end
    end
  end

  assign bus_rdy = BUS_WAIT ? bus_rdy_q : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Directed bench for cga_vram_arbiter. A second instance with the forced
// steal disabled shares all inputs. It is used to show that such a design
// waits indefinitely instead of stealing a video slot.

module tb_cga_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_l;
  logic        vid_req;
  logic [18:0] vid_addr;
  logic        cpu_cs;
  logic        cpu_memr_l;
  logic        cpu_memw_l;
  logic [14:0] cpu_a;
  logic [7:0]  cpu_d;
  logic        tandy_mode;
  logic [7:0]  ram_din;

  logic [18:0] ram_a,        ram_a_ns;
  logic        ram_we_l,     ram_we_l_ns;
  logic [7:0]  ram_dout,     ram_dout_ns;
  logic [7:0]  cpu_q,        cpu_q_ns;
  logic        bus_rdy,      bus_rdy_ns;
  logic        snow,         snow_ns;
  logic [15:0] conflict_cnt, conflict_cnt_ns;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  logic [7:0] mem [0:32767];

  always #5 clk = ~clk;

  cga_vram_arbiter #(.USE_BUS_WAIT(1), .MAX_WAIT(8), .SNOW_STEAL(1)) dut (
    .clk(clk), .reset_l(reset_l), .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_cs(cpu_cs), .cpu_memr_l(cpu_memr_l), .cpu_memw_l(cpu_memw_l),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .tandy_mode(tandy_mode), .ram_din(ram_din),
    .ram_a(ram_a), .ram_we_l(ram_we_l), .ram_dout(ram_dout), .cpu_q(cpu_q),
    .bus_rdy(bus_rdy), .snow(snow), .conflict_cnt(conflict_cnt)
  );

  cga_vram_arbiter #(.USE_BUS_WAIT(1), .MAX_WAIT(8), .SNOW_STEAL(0)) dut_ns (
    .clk(clk), .reset_l(reset_l), .vid_req(vid_req), .vid_addr(vid_addr),
    .cpu_cs(cpu_cs), .cpu_memr_l(cpu_memr_l), .cpu_memw_l(cpu_memw_l),
    .cpu_a(cpu_a), .cpu_d(cpu_d), .tandy_mode(tandy_mode), .ram_din(ram_din),
    .ram_a(ram_a_ns), .ram_we_l(ram_we_l_ns), .ram_dout(ram_dout_ns),
    .cpu_q(cpu_q_ns), .bus_rdy(bus_rdy_ns), .snow(snow_ns),
    .conflict_cnt(conflict_cnt_ns)
  );

  // Synchronous RAM model attached to the main instance.
  always @(posedge clk) begin
    if (!reset_l) begin
      mem[15'h0456] <= 8'hC3;
    end else if (!ram_we_l) begin
      mem[ram_a[14:0]] <= ram_dout;
    end
    ram_din <= mem[ram_a[14:0]];
  end

  always @(posedge clk) begin
    if (!ram_we_l) wr_cnt <= wr_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a CPU cycle. The start edge is taken on the third clock edge,
  // after the two synchronizer stages.
  task automatic start_req(input logic wr, input logic [14:0] a, input logic [7:0] d);
    cpu_a  = a;
    cpu_d  = d;
    cpu_cs = 1'b1;
    if (wr) cpu_memw_l = 1'b0;
    else    cpu_memr_l = 1'b0;
    repeat (3) tick();
  endtask

  task automatic end_req();
    cpu_memr_l = 1'b1;
    cpu_memw_l = 1'b1;
    cpu_cs     = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    reset_l    = 1'b0;
    vid_req    = 1'b0;
    vid_addr   = '0;
    cpu_cs     = 1'b0;
    cpu_memr_l = 1'b1;
    cpu_memw_l = 1'b1;
    cpu_a      = '0;
    cpu_d      = '0;
    tandy_mode = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_we",       ram_we_l,     1'b1);
    chk("rst_a",        ram_a,        19'h0);
    chk("rst_dout",     ram_dout,     8'h00);
    chk("rst_q",        cpu_q,        8'h00);
    chk("rst_rdy",      bus_rdy,      1'b1);
    chk("rst_snow",     snow,         1'b0);
    chk("rst_conflict", conflict_cnt, 16'h0);
    reset_l = 1'b1;
    repeat (2) tick();

    // Uncontended write
    start_req(1'b1, 15'h0123, 8'h5A);
    chk("wr_rdy_low",  bus_rdy,  1'b0);
    chk("wr_pend_we",  ram_we_l, 1'b1);
    tick();
    chk("wr_we",       ram_we_l, 1'b0);
    chk("wr_a",        ram_a,    19'h00123);
    chk("wr_dout",     ram_dout, 8'h5A);
    tick();
    chk("wr_we_off",   ram_we_l, 1'b1);
    chk("wr_rdy_done", bus_rdy,  1'b1);
    chk("wr_count",    wr_cnt,   32'd1);
    end_req();

    // Uncontended read
    start_req(1'b0, 15'h0456, 8'h00);
    chk("rd_rdy0",  bus_rdy,  1'b0);
    tick();
    chk("rd_a",     ram_a,    19'h00456);
    chk("rd_we",    ram_we_l, 1'b1);
    chk("rd_rdy1",  bus_rdy,  1'b0);
    tick();
    chk("rd_rdy2",  bus_rdy,  1'b0);
    chk("rd_q_old", cpu_q,    8'h00);
    tick();
    chk("rd_q",     cpu_q,    8'hC3);
    chk("rd_rdy3",  bus_rdy,  1'b1);
    chk("rd_q_ns",  cpu_q_ns, 8'hC3);
    end_req();

    // Contention: video holds the RAM for 5 cycles, then frees it
    vid_req = 1'b1;
    start_req(1'b1, 15'h0200, 8'h11);
    for (int i = 0; i < 5; i++) begin
      vid_addr = 19'h7ABC0 + 19'(i);
      #1;
      chk("ct_vid_a", ram_a,    19'h7ABC0 + 19'(i));
      chk("ct_we",    ram_we_l, 1'b1);
      chk("ct_snow",  snow,     1'b0);
      tick();
    end
    vid_req = 1'b0;
    tick();
    chk("ct_wr_we",   ram_we_l,     1'b0);
    chk("ct_wr_a",    ram_a,        19'h00200);
    chk("ct_wr_snow", snow,         1'b0);
    tick();
    chk("ct_conflict", conflict_cnt, 16'd1);
    chk("ct_rdy",      bus_rdy,      1'b1);
    chk("ct_count",    wr_cnt,       32'd2);
    end_req();

    // Aperture mapping
    tandy_mode = 1'b0;
    start_req(1'b1, 15'h4010, 8'hA1);
    tick();
    chk("ap16_we", ram_we_l, 1'b0);
    chk("ap16_a",  ram_a,    19'h00010);
    tick();
    end_req();
    tandy_mode = 1'b1;
    start_req(1'b1, 15'h4010, 8'hA2);
    tick();
    chk("ap32_we", ram_we_l, 1'b0);
    chk("ap32_a",  ram_a,    19'h04010);
    tick();
    end_req();
    tandy_mode = 1'b0;

    // Forced steal after 8 blocked cycles
    vid_req  = 1'b1;
    vid_addr = 19'h12345;
    start_req(1'b1, 15'h0777, 8'hEE);
    for (int i = 0; i < 8; i++) begin
      chk("st_blk_we",    ram_we_l,    1'b1);
      chk("st_blk_we_ns", ram_we_l_ns, 1'b1);
      chk("st_blk_snow",  snow,        1'b0);
      tick();
    end
    chk("st_we",      ram_we_l,    1'b0);
    chk("st_a",       ram_a,       19'h00777);
    chk("st_dout",    ram_dout,    8'hEE);
    chk("st_snow",    snow,        1'b1);
    chk("st_rdy",     bus_rdy,     1'b0);
    chk("st_ns_a",    ram_a_ns,    19'h12345);
    chk("st_ns_we",   ram_we_l_ns, 1'b1);
    chk("st_ns_snow", snow_ns,     1'b0);
    chk("st_ns_rdy",  bus_rdy_ns,  1'b0);
    tick();
    chk("st_snow_end",   snow,            1'b0);
    chk("st_we_end",     ram_we_l,        1'b1);
    chk("st_rdy_done",   bus_rdy,         1'b1);
    chk("st_conflict",   conflict_cnt,    16'd2);
    chk("st_conflict_ns", conflict_cnt_ns, 16'd2);
    chk("st_count",      wr_cnt,          32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("st_ns_hold_we",  ram_we_l_ns, 1'b1);
      chk("st_ns_hold_rdy", bus_rdy_ns,  1'b0);
      tick();
    end
    vid_req = 1'b0;
    tick();
    chk("st_ns_late_we",   ram_we_l_ns, 1'b0);
    chk("st_ns_late_dout", ram_dout_ns, 8'hEE);
    tick();
    chk("st_ns_late_rdy",  bus_rdy_ns,  1'b1);
    end_req();

    // Read aborted while pending
    vid_req  = 1'b1;
    vid_addr = 19'h0;
    start_req(1'b0, 15'h0456, 8'h00);
    chk("ab_rdy0", bus_rdy, 1'b0);
    tick();
    cpu_memr_l = 1'b1;
    tick();
    tick();
    chk("ab_rdy_sync", bus_rdy, 1'b0);
    tick();
    chk("ab_rdy",      bus_rdy,      1'b1);
    chk("ab_we",       ram_we_l,     1'b1);
    chk("ab_count",    wr_cnt,       32'd5);
    chk("ab_q_held",   cpu_q,        8'hC3);
    chk("ab_conflict", conflict_cnt, 16'd3);
    vid_req = 1'b0;
    end_req();

    // Reset asserted in ACCESS
    start_req(1'b1, 15'h0100, 8'h99);
    tick();
    chk("rs_access_we", ram_we_l, 1'b0);
    #1;
    reset_l = 1'b0;
    #1;
    chk("rs_we",       ram_we_l,     1'b1);
    chk("rs_a",        ram_a,        19'h0);
    chk("rs_dout",     ram_dout,     8'h00);
    chk("rs_q",        cpu_q,        8'h00);
    chk("rs_rdy",      bus_rdy,      1'b1);
    chk("rs_snow",     snow,         1'b0);
    chk("rs_conflict", conflict_cnt, 16'h0);
    cpu_memw_l = 1'b1;
    cpu_cs     = 1'b0;
    repeat (2) tick();
    reset_l = 1'b1;
    repeat (4) tick();
    chk("rs_no_write", wr_cnt,   32'd5);
    chk("rs_we_after", ram_we_l, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
